// File: rtl/fft_sram_bank.sv
// rtl/fft_sram_bank.sv - ping-pong dual-bank SRAM responder for the FFT engine
// Engine reads one bank while writing the other; host port loads/unloads while idle.
module fft_sram_bank #(
  parameter int DATA_W = 128,
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_working,
  input  logic              i_sram_read_register,
  input  logic [ADDR_W-1:0] i_raddress1,
  input  logic [ADDR_W-1:0] i_raddress2,
  output logic [DATA_W-1:0] o_rdata1,
  output logic [DATA_W-1:0] o_rdata2,
  input  logic [ADDR_W-1:0] i_waddress1,
  input  logic [ADDR_W-1:0] i_waddress2,
  input  logic [DATA_W-1:0] i_wdata1,
  input  logic [DATA_W-1:0] i_wdata2,
  input  logic              i_global_write_enable,
  input  logic              i_host_req,
  input  logic              i_host_we,
  input  logic [ADDR_W:0]   i_host_addr,
  input  logic [DATA_W-1:0] i_host_wdata,
  output logic [DATA_W-1:0] o_host_rdata,
  output logic              o_host_rvalid,
  input  logic              i_clear_status,
  output logic              o_wr_collision,
  output logic              o_host_reject
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] bank0 [DEPTH];
  logic [DATA_W-1:0] bank1 [DEPTH];

  logic              host_acc;
  logic              host_wr;
  logic              host_rd;
  logic              host_bank;
  logic [ADDR_W-1:0] host_word;
  logic              eng_wr0;
  logic              eng_wr1;
  logic              collision;
  logic              reject;

  assign host_acc  = i_host_req & ~i_working;
  assign host_wr   = host_acc & i_host_we;
  assign host_rd   = host_acc & ~i_host_we;
  assign host_bank = i_host_addr[ADDR_W];
  assign host_word = i_host_addr[ADDR_W-1:0];
  assign eng_wr0   = i_global_write_enable & i_sram_read_register;
  assign eng_wr1   = i_global_write_enable & ~i_sram_read_register;
  assign collision = i_global_write_enable & (i_waddress1 == i_waddress2);
  assign reject    = i_host_req & i_working;

  // Storage is not reset. Statement order sets priority: engine over host, port 2 over port 1.
  always_ff @(posedge clk) begin
    if (host_wr && !host_bank) bank0[host_word] <= i_host_wdata;
    if (eng_wr0) begin
      bank0[i_waddress1] <= i_wdata1;
      bank0[i_waddress2] <= i_wdata2;
    end
  end

  always_ff @(posedge clk) begin
    if (host_wr && host_bank) bank1[host_word] <= i_host_wdata;
    if (eng_wr1) begin
      bank1[i_waddress1] <= i_wdata1;
      bank1[i_waddress2] <= i_wdata2;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      o_rdata1      <= '0;
      o_rdata2      <= '0;
      o_host_rdata  <= '0;
      o_host_rvalid <= 1'b0;
    end else begin
      o_rdata1      <= i_sram_read_register ? bank1[i_raddress1] : bank0[i_raddress1];
      o_rdata2      <= i_sram_read_register ? bank1[i_raddress2] : bank0[i_raddress2];
      o_host_rvalid <= host_rd;
      if (host_rd) o_host_rdata <= host_bank ? bank1[host_word] : bank0[host_word];
    end
  end

  // Sticky status: a set event in the same cycle as a clear wins.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      o_wr_collision <= 1'b0;
      o_host_reject  <= 1'b0;
    end else begin
      o_wr_collision <= collision | (o_wr_collision & ~i_clear_status);
      o_host_reject  <= reject | (o_host_reject & ~i_clear_status);
    end
  end

endmodule

// File: tb/tb_fft_sram_bank.sv
// tb/tb_fft_sram_bank.sv - self-checking bench for fft_sram_bank
// Array model of both banks plus per-cycle compare and literal spot checks.
module tb_fft_sram_bank;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         working = 1'b0;
  logic         sel = 1'b0;
  logic [7:0]   ra1 = '0, ra2 = '0, wa1 = '0, wa2 = '0;
  logic [127:0] wd1 = '0, wd2 = '0;
  logic         gwe = 1'b0;
  logic         hreq = 1'b0, hwe = 1'b0;
  logic [8:0]   haddr = '0;
  logic [127:0] hwd = '0;
  logic         clr = 1'b0;
  logic [127:0] rd1, rd2, hrd;
  logic         hrv, col, rej;

  int n_cmp = 0;
  int n_bad = 0;

  fft_sram_bank #(.DATA_W(128), .ADDR_W(8)) dut (
    .clk(clk), .rst(rst), .i_working(working), .i_sram_read_register(sel),
    .i_raddress1(ra1), .i_raddress2(ra2), .o_rdata1(rd1), .o_rdata2(rd2),
    .i_waddress1(wa1), .i_waddress2(wa2), .i_wdata1(wd1), .i_wdata2(wd2),
    .i_global_write_enable(gwe), .i_host_req(hreq), .i_host_we(hwe),
    .i_host_addr(haddr), .i_host_wdata(hwd), .o_host_rdata(hrd),
    .o_host_rvalid(hrv), .i_clear_status(clr), .o_wr_collision(col),
    .o_host_reject(rej)
  );

  always #5 clk = ~clk;

  // Model: plain arrays with "known" bits, since memory is undefined at power-up.
  logic [127:0] m [2][256];
  bit           k [2][256];
  logic [127:0] e_r1, e_r2, e_hr;
  bit           e_r1k, e_r2k, e_hrk;
  bit           e_rv, e_col, e_rej;

  initial begin
    for (int b = 0; b < 2; b++)
      for (int a = 0; a < 256; a++) begin
        m[b][a] = '0;
        k[b][a] = 0;
      end
  end

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      e_r1 = '0; e_r2 = '0; e_hr = '0;
      e_r1k = 1; e_r2k = 1; e_hrk = 1;
      e_rv = 0; e_col = 0; e_rej = 0;
    end else begin
      int rb, wb, hb;
      bit acc;
      rb = sel ? 1 : 0;
      wb = 1 - rb;
      hb = haddr[8] ? 1 : 0;
      acc = hreq && !working;
      e_r1 = m[rb][ra1]; e_r1k = k[rb][ra1];
      e_r2 = m[rb][ra2]; e_r2k = k[rb][ra2];
      e_rv = acc && !hwe;
      if (e_rv) begin
        e_hr = m[hb][haddr[7:0]];
        e_hrk = k[hb][haddr[7:0]];
      end
      if (hreq && working) e_rej = 1; else if (clr) e_rej = 0;
      if (gwe && wa1 == wa2) e_col = 1; else if (clr) e_col = 0;
      if (acc && hwe) begin
        m[hb][haddr[7:0]] = hwd;
        k[hb][haddr[7:0]] = 1;
      end
      if (gwe) begin
        m[wb][wa1] = wd1; k[wb][wa1] = 1;
        m[wb][wa2] = wd2; k[wb][wa2] = 1;
      end
    end
  end

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    chk("rvalid", {127'b0, hrv}, {127'b0, e_rv});
    chk("collision", {127'b0, col}, {127'b0, e_col});
    chk("reject", {127'b0, rej}, {127'b0, e_rej});
    if (e_r1k) chk("rdata1", rd1, e_r1);
    if (e_r2k) chk("rdata2", rd2, e_r2);
    if (e_hrk) chk("host_rdata", hrd, e_hr);
  end

  task automatic idle();
    hreq = 0; hwe = 0; gwe = 0; clr = 0; working = 0;
  endtask

  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic hwrite(input logic [8:0] a, input logic [127:0] d);
    idle(); hreq = 1; hwe = 1; haddr = a; hwd = d; cyc();
  endtask

  task automatic hread(input logic [8:0] a);
    idle(); hreq = 1; hwe = 0; haddr = a; cyc();
  endtask

  initial begin
    cyc(); cyc();
    chk("reset_rdata1", rd1, 128'h0);
    chk("reset_host_rdata", hrd, 128'h0);
    chk("reset_rvalid", {127'b0, hrv}, 128'h0);
    rst = 0;
    cyc();

    // Host preload and read-back, back-to-back reads.
    hwrite(9'h005, 128'hA5);
    hwrite(9'h105, 128'h5A);
    hwrite(9'h003, 128'h33);
    hwrite(9'h007, 128'h77);
    hread(9'h005);
    chk("preload_b0", hrd, 128'hA5);
    chk("preload_rv0", {127'b0, hrv}, 128'h1);
    hread(9'h105);
    chk("preload_b1", hrd, 128'h5A);
    idle(); cyc();
    chk("rvalid_drop", {127'b0, hrv}, 128'h0);

    // Ping-pong: write bank1[3] while reading bank0[3], then swap.
    idle(); sel = 0; gwe = 1; wa1 = 8'd3; wa2 = 8'd4; wd1 = 128'h1234; wd2 = 128'h4444;
    ra1 = 8'd3; ra2 = 8'd5; cyc();
    chk("pingpong_old", rd1, 128'h33);
    chk("pingpong_r2", rd2, 128'hA5);
    idle(); sel = 1; ra1 = 8'd3; ra2 = 8'd5; cyc();
    chk("pingpong_new", rd1, 128'h1234);
    chk("pingpong_b1_5", rd2, 128'h5A);

    // Collision on bank0 (sel=1): port 2 wins, sticky flag, set beats clear.
    idle(); sel = 1; gwe = 1; wa1 = 8'h10; wa2 = 8'h10; wd1 = 128'h1; wd2 = 128'h2; cyc();
    chk("collision_set", {127'b0, col}, 128'h1);
    idle(); sel = 0; ra1 = 8'h10; cyc();
    chk("collision_data", rd1, 128'h2);
    idle(); sel = 1; gwe = 1; clr = 1; wa1 = 8'h11; wa2 = 8'h11; wd1 = 128'h5; wd2 = 128'h6; cyc();
    chk("collision_set_wins", {127'b0, col}, 128'h1);
    idle(); clr = 1; cyc();
    chk("collision_cleared", {127'b0, col}, 128'h0);

    // Busy reject of a host write.
    idle(); working = 1; hreq = 1; hwe = 1; haddr = 9'h007; hwd = 128'hDEAD; cyc();
    chk("reject_set", {127'b0, rej}, 128'h1);
    chk("reject_no_rv", {127'b0, hrv}, 128'h0);
    idle(); clr = 1; cyc();
    chk("reject_cleared", {127'b0, rej}, 128'h0);
    hread(9'h007);
    chk("reject_mem_kept", hrd, 128'h77);

    // Read accepted just before i_working rises still returns rvalid.
    hread(9'h105);
    chk("edge_rv", {127'b0, hrv}, 128'h1);
    idle(); working = 1; hreq = 1; hwe = 0; haddr = 9'h005; cyc();
    chk("edge_reject", {127'b0, rej}, 128'h1);
    chk("edge_no_rv", {127'b0, hrv}, 128'h0);
    idle(); clr = 1; cyc();

    // Engine write (working=0) beats a host write to the same word.
    idle(); sel = 0; hreq = 1; hwe = 1; haddr = 9'h120; hwd = 128'hAA;
    gwe = 1; wa1 = 8'h20; wa2 = 8'h21; wd1 = 128'hBB; wd2 = 128'hCC; cyc();
    hread(9'h120);
    chk("engine_wins", hrd, 128'hBB);

    // Mixed engine traffic checked by the per-cycle compare.
    for (int i = 0; i < 24; i++) begin
      idle();
      sel = i[2];
      gwe = i[0];
      wa1 = 8'(8'h40 + (i % 5)); wa2 = 8'(8'h40 + (i % 3));
      wd1 = {4{$urandom()}}; wd2 = {4{$urandom()}};
      ra1 = 8'(8'h40 + (i % 4)); ra2 = 8'(8'h42 - (i % 3));
      cyc();
    end
    idle(); clr = 1; cyc();

    // Reset in the middle of a host read.
    hreq = 1; hwe = 0; haddr = 9'h005;
    @(posedge clk); #2;
    chk("mid_pre_rv", {127'b0, hrv}, 128'h1);
    rst = 1; #1;
    chk("mid_rst_rv", {127'b0, hrv}, 128'h0);
    chk("mid_rst_rdata", hrd, 128'h0);
    idle(); cyc(); cyc();
    rst = 0;
    cyc();
    hread(9'h005);
    chk("post_rst_b0", hrd, 128'hA5);
    hread(9'h105);
    chk("post_rst_b1", hrd, 128'h5A);
    idle(); cyc();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
